// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit synchroniser followed by a stability-count debouncer.
// Emits a registered clean switch word plus one-cycle rise/fall/change pulses.
module sw_debounce #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_sw,
   output logic [WIDTH-1:0] o_sw,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall,
   output logic             o_changed
);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   state_t           r_state [WIDTH];
   state_t           w_state_nxt [WIDTH];
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
   logic [WIDTH-1:0] r_sw;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic             r_changed;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] w_sw_nxt;
   logic [WIDTH-1:0] w_rise_nxt;
   logic [WIDTH-1:0] w_fall_nxt;

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int j = 0; j < SYNC_STAGES; j++) begin
            r_sync[j] <= '0;
         end
      end else begin
         r_sync[0] <= i_sw;
         for (int j = 1; j < SYNC_STAGES; j++) begin
            r_sync[j] <= r_sync[j-1];
         end
      end
   end

   // Every mismatching cycle counts, including the first one seen in STABLE,
   // so the update lands exactly DEBOUNCE_CYCLES edges after s first differs.
   always_comb begin
      w_sw_nxt   = r_sw;
      w_rise_nxt = '0;
      w_fall_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         case (r_state[i])
            ST_STABLE: begin
               w_cnt_nxt[i] = '0;
               if (w_s[i] != r_sw[i]) begin
                  if (r_cnt[i] == LP_LAST) begin
                     w_sw_nxt[i]   = w_s[i];
                     w_rise_nxt[i] = w_s[i];
                     w_fall_nxt[i] = ~w_s[i];
                  end else begin
                     w_cnt_nxt[i]   = LP_ONE;
                     w_state_nxt[i] = ST_COUNTING;
                  end
               end
            end
            ST_COUNTING: begin
               if (w_s[i] == r_sw[i]) begin
                  w_cnt_nxt[i]   = '0;
                  w_state_nxt[i] = ST_STABLE;
               end else if (r_cnt[i] == LP_LAST) begin
                  w_sw_nxt[i]    = w_s[i];
                  w_rise_nxt[i]  = w_s[i];
                  w_fall_nxt[i]  = ~w_s[i];
                  w_cnt_nxt[i]   = '0;
                  w_state_nxt[i] = ST_STABLE;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + LP_ONE;
               end
            end
            default: begin
               w_cnt_nxt[i]   = '0;
               w_state_nxt[i] = ST_STABLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_state[i] <= ST_STABLE;
            r_cnt[i]   <= '0;
         end
         r_sw      <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_changed <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
         r_sw      <= w_sw_nxt;
         r_rise    <= w_rise_nxt;
         r_fall    <= w_fall_nxt;
         r_changed <= |(w_rise_nxt | w_fall_nxt);
      end
   end

   assign o_sw      = r_sw;
   assign o_rise    = r_rise;
   assign o_fall    = r_fall;
   assign o_changed = r_changed;

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input conditioner for board slide switches, upstream of the pipelined core's switch I/O input.
- Synchronises each asynchronous switch bit into the core clock domain and debounces it with a per-bit stability counter.
- Presents a clean, registered switch word to the core, plus one-cycle rise/fall/change pulses.
- Instantiated in the board top between the switch pins and the core's switch input.

Parameters:
- WIDTH, 16, number of switch bits conditioned.
- SYNC_STAGES, 2, flip-flops in each bit's synchroniser chain; legal range 2..4.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a new level is accepted (10 ms at 50 MHz); must be >= 1.
- CNT_W, 20, width of each per-bit counter; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.

Ports:
- i_clk  input  1  core clock (CLOCK_50 domain).
- i_rst  input  1  reset; asynchronous, active-high.
- i_sw  input  WIDTH  raw switch pins; asynchronous, bouncy.
- o_sw  output  WIDTH  debounced switch word; drives the core switch input.
- o_rise  output  WIDTH  per-bit one-cycle pulse when o_sw bit goes 0->1.
- o_fall  output  WIDTH  per-bit one-cycle pulse when o_sw bit goes 1->0.
- o_changed  output  1  one-cycle pulse; OR-reduction of o_rise | o_fall.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While i_rst=1, all synchroniser flops, counters, o_sw, o_rise, o_fall and o_changed are 0. Outputs are fully registered, with no combinational path from i_sw.
- Synchroniser: per bit, SYNC_STAGES-deep chain. The last stage, s[i], is the only value used downstream.
- Per-bit FSM, independent for each bit:
  - STABLE (s[i]==o_sw[i], cnt=0) -> COUNTING when s[i]!=o_sw[i].
  - In COUNTING, each edge:
    - s[i]==o_sw[i]: glitch rejected, cnt<=0, -> STABLE, no output change.
    - s[i]!=o_sw[i] and cnt==DEBOUNCE_CYCLES-1: o_sw[i]<=s[i], cnt<=0, -> STABLE.
    - otherwise cnt<=cnt+1.
- Evaluation order within an edge: the update check (cnt==DEBOUNCE_CYCLES-1) uses the pre-edge cnt.
- Latency: i_sw bit changes and is captured at edge k and stays stable. o_sw updates at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges including the capturing edge.
- DEBOUNCE_CYCLES=1: o_sw follows s[i] one edge after mismatch is seen. No filtering beyond the synchroniser.
- Any reversion of s[i] before the count completes restarts the count from 0. No partial credit.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- Pulses:
  - o_rise[i]/o_fall[i] are asserted on the same edge o_sw[i] changes, for exactly one cycle.
  - o_changed is registered alongside them, aligned to the same cycle.
- Simultaneous events: several bits may update on the same edge. All corresponding pulse bits assert together; o_changed asserts once.
- Reset mid-count: all state clears immediately and no pulse is emitted.
- Switch high during reset: o_sw starts at 0 after reset release. A switch held high through reset produces o_sw=1 and an o_rise pulse SYNC_STAGES+DEBOUNCE_CYCLES edges after release.

Test Plan:
- Use WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 for all scenarios.
- Reset: hold i_rst=1 with i_sw=16'hFFFF -> o_sw=0, o_rise=0, o_fall=0, o_changed=0. Release with i_sw held -> o_sw=16'hFFFF exactly 6 edges after release, with o_rise=16'hFFFF and o_changed=1 for one cycle only.
- Clean edge: i_sw[3] 0->1 captured at edge k -> o_sw[3]=1 after edge k+5, o_rise[3]=1 for that cycle only, o_fall=0.
- Bounce rejection: i_sw[0] toggles 1,0,1,0 every cycle, then settles 1 -> o_sw[0] unchanged during toggling; rises exactly 6 edges after the final settle edge; single o_rise[0] pulse.
- Short glitch: i_sw[7] high for 3 cycles then low -> o_sw[7] stays 0, no pulses, counter returns to 0.
- Simultaneous change: i_sw 16'h00F0 -> 16'h0F00 in one cycle -> after 6 edges o_sw=16'h0F00, o_rise=16'h0F00, o_fall=16'h00F0, o_changed=1, all for one cycle.
- Reset mid-count: start a 0->1 transition on bit 5, assert i_rst asynchronously at count 2 -> outputs 0 immediately, no pulse. After release with the bit held high -> full 6-edge latency re-applies.
